// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard control unit.
// The datapath is the master and drives the hazard sources; the control unit is the slave.
interface hazard_control_unit_if #(
   parameter int unsigned CNT_W = 16
);
   logic [4:0]       ID_rs1;
   logic [4:0]       ID_rs2;
   logic             ID_uses_rs1;
   logic             ID_uses_rs2;
   logic             ID_branch;
   logic             br_eq;
   logic             ID_EX_mem_read;
   logic             ID_EX_reg_write;
   logic [4:0]       ID_EX_rd;
   logic             EX_MEM_mem_read;
   logic [4:0]       EX_MEM_rd;
   logic             mem_busy;
   logic             cnt_clr;
   logic             pc_write;
   logic             IF_ID_write;
   logic             IF_flush;
   logic             pc_src;
   logic             ID_EX_bubble;
   logic             pipe_freeze;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] freeze_cnt;
   logic             freeze_err;

   modport master (
      output ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, ID_branch, br_eq,
             ID_EX_mem_read, ID_EX_reg_write, ID_EX_rd, EX_MEM_mem_read, EX_MEM_rd,
             mem_busy, cnt_clr,
      input  pc_write, IF_ID_write, IF_flush, pc_src, ID_EX_bubble, pipe_freeze,
             state, stall_cnt, flush_cnt, freeze_cnt, freeze_err
   );

   modport slave (
      input  ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, ID_branch, br_eq,
             ID_EX_mem_read, ID_EX_reg_write, ID_EX_rd, EX_MEM_mem_read, EX_MEM_rd,
             mem_busy, cnt_clr,
      output pc_write, IF_ID_write, IF_flush, pc_src, ID_EX_bubble, pipe_freeze,
             state, stall_cnt, flush_cnt, freeze_cnt, freeze_err
   );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: per-cycle RUN/STALL/FREEZE/REDIRECT decision,
// saturating event counters and a sticky memory-freeze watchdog.
module hazard_control_unit #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned FREEZE_MAX = 64
) (
   input logic                 clk,
   input logic                 reset_n,
   hazard_control_unit_if.slave hz
);
   localparam int unsigned RUN_W = $clog2(FREEZE_MAX + 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      STALL    = 2'd1,
      FREEZE   = 2'd2,
      REDIRECT = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [RUN_W-1:0] run_q;
   logic             ex_match;
   logic             mem_match;
   logic             load_use;
   logic             br_haz;

   always_comb begin
      ex_match  = (hz.ID_EX_rd != 5'd0) &&
                  ((hz.ID_uses_rs1 && (hz.ID_EX_rd == hz.ID_rs1)) ||
                   (hz.ID_uses_rs2 && (hz.ID_EX_rd == hz.ID_rs2)));
      mem_match = (hz.EX_MEM_rd != 5'd0) &&
                  ((hz.ID_uses_rs1 && (hz.EX_MEM_rd == hz.ID_rs1)) ||
                   (hz.ID_uses_rs2 && (hz.EX_MEM_rd == hz.ID_rs2)));
      load_use  = hz.ID_EX_mem_read && ex_match;
      br_haz    = hz.ID_branch &&
                  ((hz.ID_EX_reg_write && ex_match) || (hz.EX_MEM_mem_read && mem_match));
   end

   always_comb begin
      state_d         = RUN;
      hz.pc_write     = 1'b0;
      hz.IF_ID_write  = 1'b0;
      hz.IF_flush     = 1'b0;
      hz.pc_src       = 1'b0;
      hz.ID_EX_bubble = 1'b0;
      hz.pipe_freeze  = 1'b0;
      if (hz.mem_busy) begin
         state_d        = FREEZE;
         hz.pipe_freeze = 1'b1;
      end else if (load_use || br_haz) begin
         state_d         = STALL;
         hz.ID_EX_bubble = 1'b1;
      end else if (hz.ID_branch && hz.br_eq) begin
         state_d        = REDIRECT;
         hz.pc_src      = 1'b1;
         hz.pc_write    = 1'b1;
         hz.IF_ID_write = 1'b1;
         hz.IF_flush    = 1'b1;
      end else begin
         hz.pc_write    = 1'b1;
         hz.IF_ID_write = 1'b1;
      end
      // Reset overrides everything so fetch restarts cleanly at PC 0.
      if (!reset_n) begin
         state_d         = RUN;
         hz.pc_write     = 1'b0;
         hz.IF_ID_write  = 1'b0;
         hz.IF_flush     = 1'b1;
         hz.pc_src       = 1'b0;
         hz.ID_EX_bubble = 1'b1;
         hz.pipe_freeze  = 1'b0;
      end
      hz.state = state_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= RUN;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hz.stall_cnt  <= '0;
         hz.flush_cnt  <= '0;
         hz.freeze_cnt <= '0;
         hz.freeze_err <= 1'b0;
         run_q         <= '0;
      end else begin
         if (hz.cnt_clr) begin
            hz.stall_cnt  <= '0;
            hz.flush_cnt  <= '0;
            hz.freeze_cnt <= '0;
            hz.freeze_err <= 1'b0;
         end else begin
            if (state_d == STALL && hz.stall_cnt != '1)     hz.stall_cnt  <= hz.stall_cnt + 1'b1;
            if (state_d == REDIRECT && hz.flush_cnt != '1)  hz.flush_cnt  <= hz.flush_cnt + 1'b1;
            if (state_d == FREEZE && hz.freeze_cnt != '1)   hz.freeze_cnt <= hz.freeze_cnt + 1'b1;
            if (run_q == RUN_W'(FREEZE_MAX))                hz.freeze_err <= 1'b1;
         end
         // A busy run continues only if the previous cycle was itself a freeze.
         if (!hz.mem_busy)                        run_q <= '0;
         else if (state_q != FREEZE)              run_q <= RUN_W'(1);
         else if (run_q != RUN_W'(FREEZE_MAX))    run_q <= run_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed scenarios followed by random traffic,
// checked against a rule-level reference model.
module tb_hazard_control_unit;
   localparam int unsigned CW  = 4;
   localparam int unsigned FM  = 4;
   localparam int          SAT = (1 << CW) - 1;
   localparam int C_RUN = 0, C_STALL = 1, C_FREEZE = 2, C_REDIR = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   hazard_control_unit_if #(.CNT_W(CW)) bus();

   hazard_control_unit #(.CNT_W(CW), .FREEZE_MAX(FM)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .hz      (bus)
   );

   typedef struct {
      bit pcw, ifw, fl, src, bub, frz;
      int st, sc, fc, zc;
      bit err;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   m_sc = 0, m_fc = 0, m_zc = 0, m_run = 0;
   bit   m_err = 1'b0;
   int   burst = 0;

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask

   function automatic bit hits(input logic [4:0] rd);
      if (rd == 5'd0) return 1'b0;
      return (bus.ID_uses_rs1 && rd == bus.ID_rs1) || (bus.ID_uses_rs2 && rd == bus.ID_rs2);
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= SAT) ? SAT : v + 1;
   endfunction

   task automatic idle();
      bus.ID_rs1 = '0; bus.ID_rs2 = '0; bus.ID_uses_rs1 = 0; bus.ID_uses_rs2 = 0;
      bus.ID_branch = 0; bus.br_eq = 0; bus.ID_EX_mem_read = 0; bus.ID_EX_reg_write = 0;
      bus.ID_EX_rd = '0; bus.EX_MEM_mem_read = 0; bus.EX_MEM_rd = '0;
      bus.mem_busy = 0; bus.cnt_clr = 0;
   endtask

   task automatic load_use_hazard();
      bus.ID_EX_mem_read = 1; bus.ID_EX_rd = 5'd20; bus.ID_uses_rs1 = 1; bus.ID_rs1 = 5'd20;
   endtask

   // Predict this cycle from the current inputs, queue it, then advance the model one edge.
   task automatic step();
      exp_t e;
      int   cause;
      bit   hazard;
      hazard = (bus.ID_EX_mem_read && hits(bus.ID_EX_rd)) ||
               (bus.ID_branch && ((bus.ID_EX_reg_write && hits(bus.ID_EX_rd)) ||
                                  (bus.EX_MEM_mem_read && hits(bus.EX_MEM_rd))));
      if (bus.mem_busy)                      cause = C_FREEZE;
      else if (hazard)                       cause = C_STALL;
      else if (bus.ID_branch && bus.br_eq)   cause = C_REDIR;
      else                                   cause = C_RUN;
      if (!reset_n) begin
         m_sc = 0; m_fc = 0; m_zc = 0; m_err = 0; m_run = 0;
         e = '{pcw:0, ifw:0, fl:1, src:0, bub:1, frz:0, st:C_RUN, sc:0, fc:0, zc:0, err:0};
      end else begin
         e.pcw = (cause == C_RUN || cause == C_REDIR);
         e.ifw = e.pcw;
         e.fl  = (cause == C_REDIR);
         e.src = (cause == C_REDIR);
         e.bub = (cause == C_STALL);
         e.frz = (cause == C_FREEZE);
         e.st  = cause;
         e.sc  = m_sc; e.fc = m_fc; e.zc = m_zc; e.err = m_err;
      end
      sbq.push_back(e);
      if (reset_n) begin
         if (bus.cnt_clr) begin
            m_sc = 0; m_fc = 0; m_zc = 0; m_err = 0;
         end else begin
            if (cause == C_STALL)  m_sc = sat_inc(m_sc);
            if (cause == C_REDIR)  m_fc = sat_inc(m_fc);
            if (cause == C_FREEZE) m_zc = sat_inc(m_zc);
            if (m_run >= FM)       m_err = 1;
         end
         m_run = bus.mem_busy ? m_run + 1 : 0;
      end
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("pc_write",     int'(bus.pc_write),     int'(e.pcw));
         chk("IF_ID_write",  int'(bus.IF_ID_write),  int'(e.ifw));
         chk("IF_flush",     int'(bus.IF_flush),     int'(e.fl));
         chk("pc_src",       int'(bus.pc_src),       int'(e.src));
         chk("ID_EX_bubble", int'(bus.ID_EX_bubble), int'(e.bub));
         chk("pipe_freeze",  int'(bus.pipe_freeze),  int'(e.frz));
         chk("state",        int'(bus.state),        e.st);
         chk("stall_cnt",    int'(bus.stall_cnt),    e.sc);
         chk("flush_cnt",    int'(bus.flush_cnt),    e.fc);
         chk("freeze_cnt",   int'(bus.freeze_cnt),   e.zc);
         chk("freeze_err",   int'(bus.freeze_err),   int'(e.err));
      end
   end

   initial begin
      idle();
      load_use_hazard();
      @(posedge clk); #1;
      step(); step();
      reset_n = 1; idle(); step();

      load_use_hazard(); step();
      idle(); step();

      // Branch on x6 while a load of x6 moves through EX then MEM.
      bus.ID_branch = 1; bus.br_eq = 1; bus.ID_uses_rs1 = 1; bus.ID_rs1 = 5'd6;
      bus.ID_EX_mem_read = 1; bus.ID_EX_reg_write = 1; bus.ID_EX_rd = 5'd6; step();
      bus.ID_EX_mem_read = 0; bus.ID_EX_reg_write = 0; bus.ID_EX_rd = '0;
      bus.EX_MEM_mem_read = 1; bus.EX_MEM_rd = 5'd6; step();
      bus.EX_MEM_mem_read = 0; bus.EX_MEM_rd = '0; step();
      idle(); step();

      bus.ID_EX_rd = '0; bus.ID_EX_mem_read = 1; bus.ID_rs1 = '0; bus.ID_uses_rs1 = 1; step();
      idle();

      bus.ID_branch = 1; bus.br_eq = 1; bus.mem_busy = 1;
      repeat (3) step();
      bus.mem_busy = 0; step();
      idle(); step();

      bus.mem_busy = 1; repeat (5) step();
      bus.mem_busy = 0; repeat (2) step();
      bus.cnt_clr = 1; step();
      bus.cnt_clr = 0; step();

      load_use_hazard(); repeat (20) step();
      reset_n = 0; step(); step();
      reset_n = 1; idle(); step();

      repeat (3000) begin
         bus.ID_rs1 = 5'($urandom_range(0, 3)); bus.ID_rs2 = 5'($urandom_range(0, 3));
         bus.ID_uses_rs1 = 1'($urandom); bus.ID_uses_rs2 = 1'($urandom);
         bus.ID_branch = ($urandom_range(0, 2) == 0); bus.br_eq = 1'($urandom);
         bus.ID_EX_mem_read = 1'($urandom); bus.ID_EX_reg_write = 1'($urandom);
         bus.ID_EX_rd = 5'($urandom_range(0, 3));
         bus.EX_MEM_mem_read = 1'($urandom); bus.EX_MEM_rd = 5'($urandom_range(0, 3));
         if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(1, 7);
         bus.mem_busy = (burst > 0);
         if (burst > 0) burst--;
         bus.cnt_clr = ($urandom_range(0, 63) == 0);
         if (!reset_n) reset_n = 1'($urandom);
         else if ($urandom_range(0, 299) == 0) reset_n = 0;
         step();
      end
      reset_n = 1; idle(); step();

      @(negedge clk); #1;
      chk("scoreboard_drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline sequencing controller for the 5-stage RISC-V core. Each cycle it decides whether instruction fetch advances, stalls, or is redirected and flushed. It drives pc_write, IF_ID_write, IF_flush and pc_src into the fetch stage, inserts ID/EX bubbles, and freezes the back end while data memory is busy. It also keeps saturating stall/flush/freeze performance counters and a sticky memory-freeze watchdog flag.

## Interface
- CNT_W, 16, width of each performance counter
- FREEZE_MAX, 64, maximum consecutive mem_busy cycles before freeze_err sets (≥1)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID
- ID_uses_rs1, ID_uses_rs2  in  1 each  instruction in ID reads that source
- ID_branch  in  1  instruction in ID is a branch (resolved in ID)
- br_eq  in  1  ID-stage comparator result (branch taken when ID_branch & br_eq)
- ID_EX_mem_read, ID_EX_reg_write  in  1 each  control bits of the instruction in EX
- ID_EX_rd  in  5  destination register of the instruction in EX
- EX_MEM_mem_read  in  1  instruction in MEM is a load
- EX_MEM_rd  in  5  destination register of the instruction in MEM
- mem_busy  in  1  data memory not ready; the whole pipeline must hold
- cnt_clr  in  1  synchronous clear of counters and freeze_err
- pc_write  out  1  PC register enable
- IF_ID_write  out  1  IF/ID register enable
- IF_flush  out  1  zero IF/ID on next edge
- pc_src  out  1  select branch target as next PC
- ID_EX_bubble  out  1  zero ID/EX control bits on next edge
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB registers
- state  out  2  cause of the current cycle: 0 RUN, 1 STALL, 2 FREEZE, 3 REDIRECT
- stall_cnt, flush_cnt, freeze_cnt  out  CNT_W each  saturating event counters
- freeze_err  out  1  sticky watchdog flag

## Operation
- Match rules: match(rd) = rd≠0 & ((ID_uses_rs1 & rd==ID_rs1) | (ID_uses_rs2 & rd==ID_rs2)).
- load_use = ID_EX_mem_read & match(ID_EX_rd).
- br_haz = ID_branch & ((ID_EX_reg_write & match(ID_EX_rd)) | (EX_MEM_mem_read & match(EX_MEM_rd))).
- Next state is decided combinationally each cycle in strict priority order. Outputs not listed for a state are 0.
  1. FREEZE when mem_busy: pipe_freeze=1.
  2. STALL when load_use | br_haz: ID_EX_bubble=1. PC and IF/ID hold. The branch is not evaluated.
  3. REDIRECT when ID_branch & br_eq: pc_src=1, pc_write=1, IF_ID_write=1, IF_flush=1.
  4. RUN otherwise: pc_write=1, IF_ID_write=1.
- A branch whose producer is a load sitting in EX therefore stalls 2 cycles: once via EX, once via MEM. An ALU producer in EX costs 1 cycle.
- state register: holds the cause chosen for the cycle. It is updated at every posedge and mirrored combinationally on the state output.
- Counters:
  - stall_cnt +1 per STALL cycle, freeze_cnt +1 per FREEZE cycle, flush_cnt +1 per REDIRECT cycle.
  - Each counter saturates at 2^CNT_W−1.
  - cnt_clr wins over increment in the same cycle.
- Watchdog:
  - A run counter counts consecutive mem_busy cycles and clears on any cycle with mem_busy=0.
  - When the run count reaches FREEZE_MAX, freeze_err sets one cycle later. It stays set until cnt_clr or reset.
  - The run counter saturates at FREEZE_MAX.
- freeze_err is status only; it does not alter pipeline control.

## Timing
- While reset_n=0, outputs are forced: pc_write=0, IF_ID_write=0, IF_flush=1, ID_EX_bubble=1, pc_src=0, pipe_freeze=0.
- Reset values: state=RUN, all counters 0, freeze_err=0, watchdog run counter 0.
- The first cycle after reset release is evaluated normally with no extra idle cycle.
- Control outputs are combinational from the current inputs, with zero-cycle latency, and are sampled by the fetch/pipeline registers at the next edge.
- Counters and freeze_err are registered and update at the edge that ends the counted cycle.
- Simultaneous conditions:
  - mem_busy with a hazard or taken branch: FREEZE only; nothing is counted except freeze_cnt.
  - Hazard with a taken branch: STALL; the redirect occurs on the first cycle after the hazard clears.
- Asynchronous reset mid-freeze or mid-stall returns everything to reset values immediately. A pending redirect is discarded; the fetch stage restarts at PC 0.

## Test plan
- Load-use: lw x20 in EX (ID_EX_mem_read=1, rd=20), ID reads rs1=20 -> one STALL cycle with ID_EX_bubble=1, pc_write=0, IF_ID_write=0; stall_cnt=1; next cycle RUN.
- Branch after load: beq rs1=6 with lw x6 in EX -> STALL for 2 consecutive cycles; then with br_eq=1 a REDIRECT cycle (pc_src=1, IF_flush=1); stall_cnt=2, flush_cnt=1.
- x0 producer: ID_EX_rd=0, ID_EX_mem_read=1, ID_rs1=0 -> RUN, no stall.
- Freeze priority: mem_busy=1 for 3 cycles while a taken branch sits in ID -> pipe_freeze=1 and all fetch enables 0 for 3 cycles, then REDIRECT; freeze_cnt=3, flush_cnt=1.
- Watchdog: FREEZE_MAX=4, mem_busy high for 5 cycles -> freeze_err=1 and it remains 1 after mem_busy drops; cnt_clr pulse -> freeze_err=0 and all counters 0.
- Saturation and reset: CNT_W=4, 20 STALL cycles -> stall_cnt=15. Assert reset_n=0 mid-stall -> IF_flush=1, ID_EX_bubble=1, counters 0, state=RUN.
